load_store_unit: RTL
====================

# load_store_unit

Data-side memory access unit for the RV32I core. It consumes the memory control fields produced by instruction decode (MemWrite, SizeSrc, LoadSign) together with the ALU-computed address and the rs2 store data. It runs a valid/ready request and a variable-latency read-return handshake to a word-organised data memory. Loaded data is returned byte/half/word-extracted and sign- or zero-extended, with a one-cycle `done` pulse that releases the core stall.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  1: core requests an access; held stable with all request fields until `done`.
- `MemWrite`  in  1: 1 = store, 0 = load.
- `SizeSrc`  in  2: access size. 00 = word, 01 = half, 10 = byte, 11 = word.
- `LoadSign`  in  1: 1 = sign-extend loads, 0 = zero-extend.
- `addr`  in  ADDR_W: byte address from the ALU.
- `wdata`  in  32: store data (rs2).
- `rdata`  out  32: extracted, extended load result; valid while `done`=1.
- `done`  out  1: one-cycle completion pulse.
- `busy`  out  1: FSM not in IDLE; the core ORs this into its stall.
- `fault`  out  1: misaligned access; valid with `done` (see Configuration).
- `mem_req`  out  1: memory request valid.
- `mem_ready`  in  1: memory accepts the request this cycle.
- `mem_we`  out  1: write enable.
- `mem_addr`  out  ADDR_W: word-aligned address, low two bits are 00.
- `mem_be`  out  4: byte enables.
- `mem_wdata`  out  32: lane-replicated store data.
- `mem_rvalid`  in  1: read data valid (one cycle or more after acceptance).
- `mem_rdata`  in  32: read data word.

## Operation
FSM states:
- **IDLE**: If `req_valid`, register the request fields and go to REQ, or to DONE with fault when misaligned and trapping is enabled.
- **REQ**: `mem_req`=1 until `mem_ready`. On handshake, a store goes to DONE and a load goes to WAIT_R.
- **WAIT_R**: On `mem_rvalid`, register the extracted result into `rdata` and go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then return to IDLE.

Store lane mapping, with off = addr[1:0]:
- Byte: `mem_be` = 0001<<off; `mem_wdata` = {4{wdata[7:0]}}.
- Half: `mem_be` = addr[1] ? 1100 : 0011; `mem_wdata` = {2{wdata[15:0]}}.
- Word: `mem_be` = 1111; `mem_wdata` = wdata.

Load extraction:
- Byte: select byte `off` of `mem_rdata`.
- Half: select half `addr[1]`.
- Word: full word.
- Then sign-extend if `LoadSign`=1, else zero-extend.

Fields and handshake rules:
- `mem_be` is don't-care for loads; it is driven as 1111.
- Misaligned means a half with addr[0]=1, or a word with addr[1:0]≠00.
- `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are taken from registered fields and are stable while `mem_req`=1.
- `mem_rvalid` arriving outside WAIT_R is ignored.
- `mem_rvalid` in the same cycle as the `mem_ready` handshake is ignored. The memory must not return data before the cycle after acceptance.

## Timing
- Reset values: state IDLE; `rdata`=0; `done`, `busy`, `fault`, `mem_req`, `mem_we`=0; `mem_addr`=0; `mem_be`=0; `mem_wdata`=0.
- Reset mid-transaction abandons it. The cycle after `rst_n` is sampled low, `mem_req`=0 and the state is IDLE. An outstanding read return is ignored.
- Store latency: request sampled at edge N; `mem_req` high from N+1; with `mem_ready`=1 at N+1, `done` at N+2. Minimum 3 cycles from `req_valid` to `done`.
- Load latency: as for a store, plus WAIT_R. With the handshake at N+1 and `mem_rvalid` at N+2, `done` and `rdata` appear at N+3.
- Fault path (when trapping is enabled): `done`=`fault`=1 at N+1, and `mem_req` is never raised.
- `req_valid` is only sampled in IDLE. A new request presented in the cycle after `done` is accepted, so back-to-back accesses are possible.
- `busy`=1 in REQ, WAIT_R and DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access makes no memory request and produces `done`=1 with `fault`=1.
  - `rdata` stays at its previous value.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - No misalignment check; `fault` is tied to 0.
  - A half access uses addr[1] only; a word access ignores addr[1:0].
  - The access proceeds normally.

## Test plan
- Store byte: addr=0x1003, wdata=0xAABBCCDD, SizeSrc=10 → `mem_addr`=0x1000, `mem_be`=1000, `mem_wdata`=0xDDDDDDDD, `done` 2 cycles after `mem_ready`=1 at the first opportunity.
- Load byte signed: addr=0x2001, `mem_rdata`=0x12348056, LoadSign=1 → `rdata`=0x00000080 zero-extended when LoadSign=0, and 0xFFFFFF80 when LoadSign=1.
- Load half unsigned: addr=0x2002, `mem_rdata`=0xBEEF0000, LoadSign=0 → `rdata`=0x0000BEEF; the same access with LoadSign=1 → 0xFFFFBEEF.
- Backpressure: `mem_ready` held 0 for 3 cycles on a word store → `mem_req` and all `mem_*` fields stay stable, `busy`=1 throughout, `done` exactly once.
- Misaligned word load at addr=0x3002 → with `LSU_MISALIGN_TRAP_EN`: `fault`=`done`=1 one cycle after the request, `mem_req` never 1. Without it: `mem_addr`=0x3000, `fault`=0.
- Reset in WAIT_R (`rst_n`=0 for one cycle), then `mem_rvalid` arrives → next cycle state IDLE, `mem_req`=0, no `done` pulse, and the late `mem_rvalid` is ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-side memory access unit (valid/ready request, variable-latency read return).
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of issuing them.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              MemWrite,
  input  logic [1:0]        SizeSrc,
  input  logic              LoadSign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              busy,
  output logic              fault,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_e;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  state_e              state_q, state_d;
  logic [1:0]          size_q, size_d;
  logic                sign_q, sign_d;
  logic [1:0]          off_q, off_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;

  logic [3:0]          st_be;
  logic [31:0]         st_wdata;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_ext;

`ifdef LSU_MISALIGN_TRAP_EN
  logic                fault_q, fault_d;
  logic                misaligned;

  always_comb begin
    misaligned = 1'b0;
    if (SizeSrc == SZ_HALF)      misaligned = addr[0];
    else if (SizeSrc != SZ_BYTE) misaligned = (addr[1:0] != 2'b00);
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // Store lane placement; loads always enable all four lanes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata;
    case (SizeSrc)
      SZ_BYTE: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be    = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    if (!MemWrite) st_be = 4'b1111;
  end

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (off_q)
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_BYTE: ld_ext = {{24{sign_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = {{16{sign_q & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    sign_d      = sign_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    fault_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          size_d = SizeSrc;
          sign_d = LoadSign;
          off_d  = addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else
`endif
          begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = MemWrite;
            mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = st_be;
            mem_wdata_d = st_wdata;
          end
        end
      end
      S_REQ: begin
        // Read data in the handshake cycle is ignored: WAIT_R is entered only after it.
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT_R;
          end
        end
      end
      S_WAIT_R: begin
        if (mem_rvalid) begin
          rdata_d = ld_ext;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      size_q      <= '0;
      sign_q      <= 1'b0;
      off_q       <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      off_q       <= off_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q     <= fault_d;
`endif
    end
  end

  assign rdata     = rdata_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
